// File: rtl/vram_bus_master_pkg.sv
// Shared VRAM bus parameters and the bus-master phase encoding.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package vram_bus_master_pkg;

  // Width of the VRAM address bus and the resulting device size.
  localparam int VRAM_ADDR_WIDTH = 16;
  localparam int VRAM_SIZE       = 1 << VRAM_ADDR_WIDTH;

  // Bus-master phases: IDLE -> SETUP -> ACCESS (WAIT_CYCLES) -> HOLD -> IDLE.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_HOLD   = 2'd3
  } vbm_state_e;

endpackage

// File: rtl/vram_bus_master_m.sv
// Initiator for the asynchronous VRAM bus: one request at a time, sequenced as setup/access/hold.
// Latency: handshake at end of cycle T -> rsp_valid in cycle T+2+WAIT_CYCLES; one request per 3+WAIT_CYCLES cycles.
// Backpressure: req_ready is high only in IDLE; requests wait on req_valid until accepted.
//
// Ports:
//   clk, rst_n                    clock, synchronous active-low reset
//   req_valid/req_ready           request handshake; req_write, req_addr, req_wdata latched on accept
//   rsp_valid, rsp_rdata          one-cycle read-complete strobe and held read data
//   vram_address, vram_data       bus address and bidirectional data (driven only during writes)
//   vram_we, vram_oe, vram_cs     active-high write enable, output enable, chip select
module vram_bus_master_m
  import vram_bus_master_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int ADDR_WIDTH  = VRAM_ADDR_WIDTH,
  parameter int WAIT_CYCLES = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic [ADDR_WIDTH-1:0] vram_address,
  inout  wire  [DATA_WIDTH-1:0] vram_data,
  output logic                  vram_we,
  output logic                  vram_oe,
  output logic                  vram_cs
);

  if (WAIT_CYCLES < 1) begin : g_bad_wait
    $error("vram_bus_master_m: WAIT_CYCLES must be >= 1");
  end

  localparam int              CNT_W      = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(WAIT_CYCLES - 1);

  vbm_state_e            state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  write_q, write_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  ready_q, ready_d;
  logic                  rsp_q, rsp_d;
  logic                  cs_q, cs_d;
  logic                  we_q, we_d;
  logic                  oe_q, oe_d;
  logic                  drv_q, drv_d;

  // Next state plus the next value of every bus output. Outputs are derived
  // from the next state so that all bus pins come straight from flops.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    write_d = write_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;

    case (state_q)
      ST_IDLE: begin
        if (req_valid && ready_q) begin
          state_d = ST_SETUP;
          write_d = req_write;
          addr_d  = req_addr;
          wdata_d = req_wdata;
        end
      end
      ST_SETUP: begin
        state_d = ST_ACCESS;
        cnt_d   = CNT_RELOAD;
      end
      ST_ACCESS: begin
        if (cnt_q == '0) begin
          state_d = ST_HOLD;
          // Sample on the edge that ends the last strobe cycle; X/Z pass through.
          if (!write_q) rdata_d = vram_data;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_HOLD: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    ready_d = (state_d == ST_IDLE);
    cs_d    = (state_d != ST_IDLE);
    we_d    = (state_d == ST_ACCESS) &&  write_d;
    oe_d    = (state_d == ST_ACCESS) && !write_d;
    // Write data spans SETUP..HOLD for setup and hold time around we.
    drv_d   = (state_d != ST_IDLE) &&  write_d;
    rsp_d   = (state_d == ST_HOLD) && !write_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      write_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      ready_q <= 1'b0;
      rsp_q   <= 1'b0;
      cs_q    <= 1'b0;
      we_q    <= 1'b0;
      oe_q    <= 1'b0;
      drv_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      write_q <= write_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      ready_q <= ready_d;
      rsp_q   <= rsp_d;
      cs_q    <= cs_d;
      we_q    <= we_d;
      oe_q    <= oe_d;
      drv_q   <= drv_d;
    end
  end

  assign req_ready    = ready_q;
  assign rsp_valid    = rsp_q;
  assign rsp_rdata    = rdata_q;
  assign vram_address = addr_q;
  assign vram_we      = we_q;
  assign vram_oe      = oe_q;
  assign vram_cs      = cs_q;
  assign vram_data    = drv_q ? wdata_q : {DATA_WIDTH{1'bz}};

endmodule

// File: tb/tb_vram_bus_master_m.sv
// Directed bench for vram_bus_master_m with a simple VRAM model on each bus.
// DUT A uses WAIT_CYCLES=1, DUT B uses WAIT_CYCLES=3.
// Inputs driven 1 time unit after the rising edge; outputs sampled there or on the falling edge.
module tb_vram_bus_master_m;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  always #5 clk = ~clk;

  // DUT A (WAIT_CYCLES = 1)
  logic        req_valid = 1'b0, req_write = 1'b0;
  logic [15:0] req_addr = '0;
  logic [7:0]  req_wdata = '0;
  logic        req_ready, rsp_valid;
  logic [7:0]  rsp_rdata;
  logic [15:0] addr_a;
  wire  [7:0]  data_a;
  logic        we_a, oe_a, cs_a;

  // DUT B (WAIT_CYCLES = 3)
  logic        b_req_valid = 1'b0, b_req_write = 1'b0;
  logic [15:0] b_req_addr = '0;
  logic [7:0]  b_req_wdata = '0;
  logic        b_req_ready, b_rsp_valid;
  logic [7:0]  b_rsp_rdata;
  logic [15:0] addr_b;
  wire  [7:0]  data_b;
  logic        we_b, oe_b, cs_b;

  vram_bus_master_m #(.DATA_WIDTH(8), .ADDR_WIDTH(16), .WAIT_CYCLES(1)) u_dut_a (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .vram_address(addr_a), .vram_data(data_a),
    .vram_we(we_a), .vram_oe(oe_a), .vram_cs(cs_a)
  );

  vram_bus_master_m #(.DATA_WIDTH(8), .ADDR_WIDTH(16), .WAIT_CYCLES(3)) u_dut_b (
    .clk(clk), .rst_n(rst_n),
    .req_valid(b_req_valid), .req_ready(b_req_ready), .req_write(b_req_write),
    .req_addr(b_req_addr), .req_wdata(b_req_wdata),
    .rsp_valid(b_rsp_valid), .rsp_rdata(b_rsp_rdata),
    .vram_address(addr_b), .vram_data(data_b),
    .vram_we(we_b), .vram_oe(oe_b), .vram_cs(cs_b)
  );

  // VRAM models: drive data while selected for a read, capture on write edges.
  logic [7:0] mem_a [0:65535];
  logic [7:0] mem_b [0:255];
  assign data_a = (cs_a && oe_a && !we_a) ? mem_a[addr_a] : 8'bz;
  assign data_b = (cs_b && oe_b && !we_b) ? mem_b[addr_b[7:0]] : 8'bz;
  always @(posedge clk) if (cs_a && we_a) mem_a[addr_a] <= data_a;
  always @(posedge clk) if (cs_b && we_b) mem_b[addr_b[7:0]] <= data_b;

  int   checks = 0;
  int   errors = 0;
  logic mon_en = 1'b0;
  logic [7:0] cur_wdata = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Bus invariants on every cycle once out of reset.
  always @(negedge clk) begin
    if (mon_en) begin
      chk("a_we_oe_excl", {31'd0, we_a & oe_a}, 32'd0);
      chk("b_we_oe_excl", {31'd0, we_b & oe_b}, 32'd0);
      if (cs_a && we_a) chk("a_wr_bus_dat", {24'd0, data_a}, {24'd0, cur_wdata});
    end
  end

  // One access on DUT A with a per-cycle trace of {cs,we,oe,ready}.
  task automatic do_access(input logic wr, input logic [15:0] a, input logic [7:0] d,
                           input logic [7:0] exp_rd);
    chk("pre_ready", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1; req_write = wr; req_addr = a; req_wdata = d;
    if (wr) cur_wdata = d;
    tick();
    req_valid = 1'b0;
    chk("setup_pins", {28'd0, cs_a, we_a, oe_a, req_ready}, 32'b1000);
    chk("setup_addr", {16'd0, addr_a}, {16'd0, a});
    chk("setup_rsp", {31'd0, rsp_valid}, 32'd0);
    if (wr) chk("setup_wdat", {24'd0, data_a}, {24'd0, d});
    tick();
    chk("access_pins", {28'd0, cs_a, we_a, oe_a, req_ready}, wr ? 32'b1100 : 32'b1010);
    tick();
    chk("hold_pins", {28'd0, cs_a, we_a, oe_a, req_ready}, 32'b1000);
    chk("hold_addr", {16'd0, addr_a}, {16'd0, a});
    chk("hold_rsp", {31'd0, rsp_valid}, {31'd0, !wr});
    if (wr) chk("hold_wdat", {24'd0, data_a}, {24'd0, d});
    else    chk("hold_rdata", {24'd0, rsp_rdata}, {24'd0, exp_rd});
    tick();
    chk("idle_pins", {28'd0, cs_a, we_a, oe_a, req_ready}, 32'b0001);
    chk("idle_rsp", {31'd0, rsp_valid}, 32'd0);
  endtask

  logic        wr_v   [8];
  logic [15:0] addr_v [8];
  logic [7:0]  dat_v  [8];
  logic [7:0]  got;
  int          n_oe, rsp_at;

  initial begin
    mem_a[16'h0020] = 8'h5A;
    mem_b[8'h40]    = 8'h3C;

    // Reset state.
    repeat (3) tick();
    chk("rst_ready", {31'd0, req_ready}, 32'd0);
    chk("rst_pins", {29'd0, cs_a, we_a, oe_a}, 32'd0);
    chk("rst_rsp", {31'd0, rsp_valid}, 32'd0);
    chk("rst_rdata", {24'd0, rsp_rdata}, 32'd0);
    chk("rst_addr", {16'd0, addr_a}, 32'd0);
    rst_n = 1'b1;
    tick();
    mon_en = 1'b1;
    chk("post_rst_ready", {31'd0, req_ready}, 32'd1);

    // Idle with no requests.
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("idle_ready", {31'd0, req_ready}, 32'd1);
      chk("idle_cs", {31'd0, cs_a}, 32'd0);
      chk("idle_rsp", {31'd0, rsp_valid}, 32'd0);
    end

    // Write then read back.
    do_access(1'b1, 16'h0010, 8'hA5, 8'h00);
    chk("mem_10", {24'd0, mem_a[16'h0010]}, 32'hA5);
    do_access(1'b0, 16'h0010, 8'h00, 8'hA5);
    tick();
    chk("rdata_held", {24'd0, rsp_rdata}, 32'hA5);

    // Back-to-back alternating write/read, req_valid held high.
    wr_v[0] = 1'b1; addr_v[0] = 16'h0000; dat_v[0] = 8'h11;
    wr_v[1] = 1'b0; addr_v[1] = 16'h0000; dat_v[1] = 8'h11;
    wr_v[2] = 1'b1; addr_v[2] = 16'hFFFF; dat_v[2] = 8'h22;
    wr_v[3] = 1'b0; addr_v[3] = 16'hFFFF; dat_v[3] = 8'h22;
    wr_v[4] = 1'b1; addr_v[4] = 16'h0000; dat_v[4] = 8'h33;
    wr_v[5] = 1'b0; addr_v[5] = 16'h0000; dat_v[5] = 8'h33;
    wr_v[6] = 1'b1; addr_v[6] = 16'hFFFF; dat_v[6] = 8'h44;
    wr_v[7] = 1'b0; addr_v[7] = 16'hFFFF; dat_v[7] = 8'h44;
    req_valid = 1'b1; req_write = wr_v[0]; req_addr = addr_v[0]; req_wdata = dat_v[0];
    for (int i = 0; i < 8; i++) begin
      chk("b2b_ready_hi", {31'd0, req_ready}, 32'd1);
      tick();
      if (wr_v[i]) cur_wdata = dat_v[i];
      if (i < 7) begin
        req_write = wr_v[i+1]; req_addr = addr_v[i+1]; req_wdata = dat_v[i+1];
      end else begin
        req_valid = 1'b0;
      end
      chk("b2b_addr", {16'd0, addr_a}, {16'd0, addr_v[i]});
      chk("b2b_ready_lo1", {31'd0, req_ready}, 32'd0);
      tick();
      chk("b2b_ready_lo2", {31'd0, req_ready}, 32'd0);
      tick();
      chk("b2b_ready_lo3", {31'd0, req_ready}, 32'd0);
      chk("b2b_rsp", {31'd0, rsp_valid}, {31'd0, !wr_v[i]});
      if (!wr_v[i]) chk("b2b_rdata", {24'd0, rsp_rdata}, {24'd0, dat_v[i]});
      tick();
    end
    chk("b2b_mem_max", {24'd0, mem_a[16'hFFFF]}, 32'h44);

    // Reset during the ACCESS phase of a write.
    chk("rst_pre_ready", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 16'h0020; req_wdata = 8'hFF;
    cur_wdata = 8'hFF;
    tick();
    req_valid = 1'b0;
    tick();
    chk("rst_mid_we", {31'd0, we_a}, 32'd1);
    rst_n = 1'b0;
    tick();
    chk("rst_mid_pins", {29'd0, cs_a, we_a, oe_a}, 32'd0);
    chk("rst_mid_rsp", {31'd0, rsp_valid}, 32'd0);
    chk("rst_mid_ready", {31'd0, req_ready}, 32'd0);
    rst_n = 1'b1;
    tick();
    chk("rst_rel_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_rel_rsp", {31'd0, rsp_valid}, 32'd0);
    req_valid = 1'b1; req_write = 1'b0; req_addr = 16'h0020;
    tick();
    req_valid = 1'b0;
    tick();
    tick();
    chk("rst_rd_rsp", {31'd0, rsp_valid}, 32'd1);
    got = rsp_rdata;
    chk("rst_rd_val", {31'd0, (got === 8'h5A) || (got === 8'hFF)}, 32'd1);
    tick();

    // WAIT_CYCLES = 3 read on DUT B.
    chk("b_pre_ready", {31'd0, b_req_ready}, 32'd1);
    b_req_valid = 1'b1; b_req_write = 1'b0; b_req_addr = 16'h0040;
    tick();
    b_req_valid = 1'b0;
    n_oe = 0; rsp_at = 0;
    for (int k = 1; k <= 8; k++) begin
      if (oe_b) n_oe++;
      if (b_rsp_valid && rsp_at == 0) begin
        rsp_at = k;
        got = b_rsp_rdata;
      end
      tick();
    end
    chk("b_oe_cycles", n_oe, 32'd3);
    chk("b_rsp_cycle", rsp_at, 32'd5);
    chk("b_rdata", {24'd0, got}, 32'h3C);
    chk("b_end_ready", {31'd0, b_req_ready}, 32'd1);

    mon_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
